// File: rtl/gc_pkg.sv
// Shared types and constants for the game controller poller.
package gc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TX_BIT,
    TX_STOP,
    RX_WAIT,
    RX_SAMPLE
  } gc_state_e;

  // Upper 16 bits of the poll command; the low byte carries the rumble flag.
  localparam logic [15:0] CMD_POLL_HI = 16'h4003;
  localparam int TX_BITS = 24;
  localparam int RX_BITS = 64;

  // Larger of two counts, used to size a timer shared by several phases.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/gc_line_sync.sv
// Two-flop synchronizer for the controller data pad plus a falling-edge detector.
// All flops come out of reset high so an idle-high line never looks like an edge.
module gc_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic line_in,
  output logic level,
  output logic fall
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q, prev_d;

  // Shift the pad level through the synchronizer and keep one extra stage for edge detection.
  always_comb begin
    sync1_d = line_in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  // Synchronizer registers, reset to the idle-high line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  assign level = sync2_q;
  assign fall  = prev_q & ~sync2_q;

endmodule

// File: rtl/gc_poller.sv
// Game controller poller: sends the 24-bit poll command on the open-drain data line,
// then captures the 64-bit reply, with a per-edge timeout while waiting for the controller.
module gc_poller
  import gc_pkg::*;
#(
  parameter int CYC_PER_US = 100,
  parameter int TIMEOUT_US = 200
) (
  input  logic        SYSCLK,
  input  logic        SYSRESET,
  input  logic        start,
  input  logic        rumble,
  input  logic        line_in,
  output logic        line_oe,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic [63:0] data
);

  localparam int CELL_CYC = 4 * CYC_PER_US;
  localparam int TMO_CYC  = TIMEOUT_US * CYC_PER_US;
  localparam int TMR_W    = $clog2(max_int(CELL_CYC, TMO_CYC) + 1);
  localparam int TXI_W    = $clog2(TX_BITS);
  localparam int RXC_W    = $clog2(RX_BITS);

  localparam logic [TMR_W-1:0] CELL_LAST   = TMR_W'(CELL_CYC - 1);
  localparam logic [TMR_W-1:0] US_LAST     = TMR_W'(CYC_PER_US - 1);
  localparam logic [TMR_W-1:0] SAMPLE_LAST = TMR_W'(2 * CYC_PER_US - 1);
  localparam logic [TMR_W-1:0] TMO_LAST    = TMR_W'(TMO_CYC - 1);
  localparam logic [TMR_W-1:0] ONE_US      = TMR_W'(CYC_PER_US);
  localparam logic [TMR_W-1:0] THREE_US    = TMR_W'(3 * CYC_PER_US);
  localparam logic [TXI_W-1:0] TX_LAST     = TXI_W'(TX_BITS - 1);
  localparam logic [RXC_W-1:0] RX_LAST     = RXC_W'(RX_BITS - 1);

  gc_state_e            state_q, state_d;
  logic [TMR_W-1:0]     tmr_q, tmr_d;
  logic [TXI_W-1:0]     tx_idx_q, tx_idx_d;
  logic [RXC_W-1:0]     rx_cnt_q, rx_cnt_d;
  logic [TX_BITS-1:0]   cmd_q, cmd_d;
  logic [RX_BITS-1:0]   shift_q, shift_d;
  logic [RX_BITS-1:0]   data_q, data_d;
  logic                 done_q, done_d;
  logic                 timeout_q, timeout_d;
  logic                 rx_level;
  logic                 rx_fall;

  gc_line_sync u_line_sync (
    .clk     (SYSCLK),
    .rst     (SYSRESET),
    .line_in (line_in),
    .level   (rx_level),
    .fall    (rx_fall)
  );

  // State and datapath registers; reset abandons any transaction without a status pulse.
  always_ff @(posedge SYSCLK) begin
    if (SYSRESET) begin
      state_q   <= IDLE;
      tmr_q     <= '0;
      tx_idx_q  <= '0;
      rx_cnt_q  <= '0;
      cmd_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      tx_idx_q  <= tx_idx_d;
      rx_cnt_q  <= rx_cnt_d;
      cmd_q     <= cmd_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state logic: one shared timer paces bit cells, the stop bit, the sample point and the timeout.
  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    tx_idx_d  = tx_idx_q;
    rx_cnt_d  = rx_cnt_q;
    cmd_d     = cmd_q;
    shift_d   = shift_q;
    data_d    = data_q;
    done_d    = 1'b0;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = TX_BIT;
          cmd_d    = {CMD_POLL_HI, 7'b0, rumble};
          tmr_d    = '0;
          tx_idx_d = '0;
          rx_cnt_d = '0;
        end
      end
      TX_BIT: begin
        if (tmr_q == CELL_LAST) begin
          tmr_d = '0;
          cmd_d = {cmd_q[TX_BITS-2:0], 1'b0};
          if (tx_idx_q == TX_LAST) begin
            state_d = TX_STOP;
          end else begin
            tx_idx_d = tx_idx_q + 1'b1;
          end
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      TX_STOP: begin
        if (tmr_q == US_LAST) begin
          state_d = RX_WAIT;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      RX_WAIT: begin
        if (rx_fall) begin
          state_d = RX_SAMPLE;
          tmr_d   = '0;
        end else if (tmr_q == TMO_LAST) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
          tmr_d     = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      RX_SAMPLE: begin
        if (tmr_q == SAMPLE_LAST) begin
          shift_d = {shift_q[RX_BITS-2:0], rx_level};
          tmr_d   = '0;
          if (rx_cnt_q == RX_LAST) begin
            data_d  = {shift_q[RX_BITS-2:0], rx_level};
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            rx_cnt_d = rx_cnt_q + 1'b1;
            state_d  = RX_WAIT;
          end
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode: pull the line low for the first part of each cell and for the host stop bit.
  always_comb begin
    line_oe = 1'b0;
    busy    = (state_q != IDLE);
    case (state_q)
      TX_BIT:  line_oe = cmd_q[TX_BITS-1] ? (tmr_q < ONE_US) : (tmr_q < THREE_US);
      TX_STOP: line_oe = 1'b1;
      default: line_oe = 1'b0;
    endcase
  end

  assign done    = done_q;
  assign timeout = timeout_q;
  assign data    = data_q;

endmodule

// File: tb/tb_gc_poller.sv
// Self-checking bench for gc_poller with a small open-drain controller model.
module tb_gc_poller;

  localparam int CYC        = 4;
  localparam int TMO_US     = 200;
  localparam int CELL       = 4 * CYC;
  localparam int TX_LEN     = 24 * CELL + CYC;
  localparam int REPLY_GAP  = 2 * CYC;
  localparam int MAX_CYCLES = 2600;
  localparam int NVEC       = 8;

  logic        SYSCLK = 1'b0;
  logic        SYSRESET = 1'b1;
  logic        start = 1'b0;
  logic        rumble = 1'b0;
  logic        ctrl_low = 1'b0;
  logic        line_in;
  logic        line_oe;
  logic        busy;
  logic        done;
  logic        timeout;
  logic [63:0] data;

  // Open-drain wire with pull-up: either side pulling low wins.
  assign line_in = !(line_oe || ctrl_low);

  gc_poller #(
    .CYC_PER_US (CYC),
    .TIMEOUT_US (TMO_US)
  ) dut (
    .SYSCLK   (SYSCLK),
    .SYSRESET (SYSRESET),
    .start    (start),
    .rumble   (rumble),
    .line_in  (line_in),
    .line_oe  (line_oe),
    .busy     (busy),
    .done     (done),
    .timeout  (timeout),
    .data     (data)
  );

  always #5 SYSCLK = ~SYSCLK;

  typedef struct {
    logic        rumble;
    logic [63:0] reply;
    int          nbits;
    logic        glitch;
    logic        exp_done;
  } vec_t;

  vec_t        vecs[NVEC];
  int          checks = 0;
  int          errors = 0;
  logic [63:0] model_data = 64'h0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic checkInt(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkRange(input string name, input int actual, input int lo, input int hi);
    checks++;
    if (actual < lo || actual > hi) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d..%0d", name, actual, lo, hi);
    end
  endtask

  // Line-level waveform of one cell: a '1' is short low (1us), a '0' is long low (3us).
  function automatic logic cellLow(input logic b, input int off);
    return b ? (off < CYC) : (off < 3 * CYC);
  endfunction

  // Expected host pull-down n cycles after start is accepted: 24 command cells, then a 1us stop.
  function automatic logic expTx(input logic [23:0] cmd, input int n);
    if (n >= 24 * CELL) return (n < TX_LEN);
    return cellLow(cmd[23 - n / CELL], n % CELL);
  endfunction

  // Controller pull-down: reply starts REPLY_GAP cycles after the host releases the line.
  function automatic logic ctrlLow(input vec_t v, input int n);
    int rel;
    rel = n - (TX_LEN + REPLY_GAP);
    if (rel < 0 || rel / CELL >= v.nbits) return 1'b0;
    return cellLow(v.reply[63 - rel / CELL], rel % CELL);
  endfunction

  // Runs one poll transaction cycle by cycle, playing the controller and checking the outcome.
  task automatic applyStimulus(input vec_t v);
    logic [23:0] cmd;
    int txErr, firstBad, busyTxLow, high0, high23;
    int doneCnt, tmoCnt, doneAt, tmoAt, both, lastFall;
    logic busyAtDone, busyAtTmo;
    cmd = {16'h4003, 7'b0, v.rumble};
    txErr = 0; firstBad = -1; busyTxLow = 0; high0 = 0; high23 = 0;
    doneCnt = 0; tmoCnt = 0; doneAt = -1; tmoAt = -1; both = 0;
    busyAtDone = 1'b1; busyAtTmo = 1'b1;
    lastFall = TX_LEN + REPLY_GAP + (v.nbits - 1) * CELL;

    @(negedge SYSCLK);
    start  = 1'b1;
    rumble = v.rumble;
    @(negedge SYSCLK);
    start  = 1'b0;
    rumble = ~v.rumble;

    for (int n = 0; n < MAX_CYCLES; n++) begin
      ctrl_low = ctrlLow(v, n);
      if (v.glitch && n == 40) begin
        start  = 1'b1;
        rumble = ~v.rumble;
      end else begin
        start = 1'b0;
      end
      if (n <= TX_LEN && line_oe !== expTx(cmd, n)) begin
        txErr++;
        if (firstBad < 0) firstBad = n;
      end
      if (n < TX_LEN && busy !== 1'b1) busyTxLow++;
      if (n < CELL && line_oe === 1'b1) high0++;
      if (n >= 23 * CELL && n < 24 * CELL && line_oe === 1'b1) high23++;
      if (done === 1'b1) begin
        doneCnt++;
        if (doneAt < 0) begin
          doneAt = n;
          busyAtDone = busy;
        end
      end
      if (timeout === 1'b1) begin
        tmoCnt++;
        if (tmoAt < 0) begin
          tmoAt = n;
          busyAtTmo = busy;
        end
      end
      if (done === 1'b1 && timeout === 1'b1) both++;
      if (doneAt >= 0 && n >= doneAt + 4) break;
      if (tmoAt >= 0 && n >= tmoAt + 4) break;
      @(negedge SYSCLK);
    end
    ctrl_low = 1'b0;
    start    = 1'b0;

    if (txErr != 0) $display("[TB] first bad TX cycle %0d", firstBad);
    checkInt("tx_waveform_errors", txErr, 0);
    checkInt("busy_low_during_tx", busyTxLow, 0);
    checkInt("cell0_pull_cycles", high0, 3 * CYC);
    checkInt("cell23_pull_cycles", high23, v.rumble ? CYC : 3 * CYC);
    checkInt("done_timeout_overlap", both, 0);
    if (v.exp_done) begin
      checkInt("done_pulses", doneCnt, 1);
      checkInt("timeout_pulses", tmoCnt, 0);
      checkOutput("busy_at_done", {63'b0, busyAtDone}, 64'd0);
      checkRange("done_latency", doneAt, lastFall + 2 * CYC, lastFall + 2 * CYC + 6);
      model_data = v.reply;
    end else begin
      checkInt("timeout_pulses", tmoCnt, 1);
      checkInt("done_pulses", doneCnt, 0);
      checkOutput("busy_at_timeout", {63'b0, busyAtTmo}, 64'd0);
      if (v.nbits == 0)
        checkInt("timeout_cycle", tmoAt, TX_LEN + TMO_US * CYC);
      else
        checkRange("timeout_cycle", tmoAt, lastFall + 2 * CYC + TMO_US * CYC,
                   lastFall + 2 * CYC + TMO_US * CYC + 6);
    end
    checkOutput("data", data, model_data);
  endtask

  // Resets the block in the middle of a reply and checks it aborts silently.
  task automatic resetMidRx(input vec_t v);
    int stray;
    int busyHigh;
    stray = 0;
    busyHigh = 0;
    @(negedge SYSCLK);
    start  = 1'b1;
    rumble = v.rumble;
    @(negedge SYSCLK);
    start = 1'b0;
    for (int n = 0; n < TX_LEN + REPLY_GAP + 20 * CELL; n++) begin
      ctrl_low = ctrlLow(v, n);
      @(negedge SYSCLK);
    end
    checkOutput("busy_before_reset", {63'b0, busy}, 64'd1);
    SYSRESET = 1'b1;
    @(negedge SYSCLK);
    checkOutput("rst_mid_line_oe", {63'b0, line_oe}, 64'd0);
    checkOutput("rst_mid_busy", {63'b0, busy}, 64'd0);
    checkOutput("rst_mid_done", {63'b0, done}, 64'd0);
    checkOutput("rst_mid_timeout", {63'b0, timeout}, 64'd0);
    checkOutput("rst_mid_data", data, 64'd0);
    model_data = 64'h0;
    SYSRESET = 1'b0;
    for (int n = TX_LEN + REPLY_GAP + 20 * CELL + 1; n < TX_LEN + REPLY_GAP + 20 * CELL + 1200; n++) begin
      ctrl_low = ctrlLow(v, n);
      if (done === 1'b1 || timeout === 1'b1) stray++;
      if (busy !== 1'b0) busyHigh++;
      @(negedge SYSCLK);
    end
    ctrl_low = 1'b0;
    checkInt("post_reset_pulses", stray, 0);
    checkInt("post_reset_busy", busyHigh, 0);
    checkOutput("post_reset_data", data, model_data);
  endtask

  // Top-level sequence: fixed corner-case vectors first, then random ones, then the reset abort.
  initial begin
    vec_t rv;
    vecs[0] = '{rumble: 1'b0, reply: 64'h0, nbits: 0, glitch: 1'b0, exp_done: 1'b0};
    vecs[1] = '{rumble: 1'b0, reply: 64'h0080_8080_8080_1F1F, nbits: 64, glitch: 1'b1, exp_done: 1'b1};
    vecs[2] = '{rumble: 1'b1, reply: 64'hFFFF_0000_A5A5_5A5A, nbits: 40, glitch: 1'b0, exp_done: 1'b0};
    vecs[3] = '{rumble: 1'b1, reply: 64'hDEAD_BEEF_0123_4567, nbits: 64, glitch: 1'b1, exp_done: 1'b1};
    for (int i = 4; i < NVEC; i++) begin
      rv.rumble = 1'($urandom_range(0, 1));
      rv.reply  = {32'($urandom), 32'($urandom)};
      rv.nbits  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 63)) : 64;
      rv.glitch = 1'($urandom_range(0, 1));
      rv.exp_done = (rv.nbits == 64);
      vecs[i] = rv;
    end

    repeat (3) @(negedge SYSCLK);
    checkOutput("reset_line_oe", {63'b0, line_oe}, 64'd0);
    checkOutput("reset_busy", {63'b0, busy}, 64'd0);
    checkOutput("reset_done", {63'b0, done}, 64'd0);
    checkOutput("reset_timeout", {63'b0, timeout}, 64'd0);
    checkOutput("reset_data", data, 64'd0);
    SYSRESET = 1'b0;
    repeat (4) @(negedge SYSCLK);
    checkOutput("idle_busy", {63'b0, busy}, 64'd0);

    for (int i = 0; i < NVEC; i++) begin
      $display("[TB] vector %0d rumble=%0d nbits=%0d glitch=%0d", i, vecs[i].rumble, vecs[i].nbits, vecs[i].glitch);
      applyStimulus(vecs[i]);
      repeat (5) @(negedge SYSCLK);
    end

    rv = '{rumble: 1'b0, reply: 64'h1234_5678_9ABC_DEF0, nbits: 64, glitch: 1'b0, exp_done: 1'b1};
    resetMidRx(rv);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
